// File: rtl/spsram_fifo_ctrl.sv
// FIFO controller that uses a single-port SRAM as storage, sharing the port
// between stream writes and prefetch reads into a 2-entry output buffer.
module spsram_fifo_ctrl #(
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned BW_ADDR = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [BW_DATA-1:0]   i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [BW_DATA-1:0]   o_out_data,
  input  logic                 i_out_ready,
  output logic                 o_out_valid,
  output logic [BW_ADDR+1:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [BW_DATA-1:0]   o_sram_data,
  output logic [BW_ADDR-1:0]   o_sram_addr,
  output logic                 o_sram_cen,
  output logic                 o_sram_wen,
  output logic                 o_sram_oen,
  input  logic [BW_DATA-1:0]   i_sram_data
);

  localparam int unsigned PW    = BW_ADDR + 1;
  localparam int unsigned CW    = BW_ADDR + 2;
  localparam int unsigned DEPTH = 2 ** BW_ADDR;

  typedef enum logic {
    TOK_RD = 1'b0,
    TOK_WR = 1'b1
  } token_e;

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      mem_cnt;
  logic               inflight;
  logic [1:0]         obuf_cnt;
  logic [BW_DATA-1:0] obuf0;
  logic [BW_DATA-1:0] obuf1;
  token_e             token;

  logic [1:0] occ;
  logic [1:0] wsel;
  logic       rd_req;
  logic       wr_fire;
  logic       rd_grant;
  logic       push;
  logic       pop;

  // Arbitration: a pending read with the token blocks the write stream
  always_comb begin
    mem_cnt     = wr_ptr - rd_ptr;
    o_full      = (mem_cnt == PW'(DEPTH));
    occ         = obuf_cnt + 2'(inflight);
    rd_req      = (mem_cnt != '0) && (occ < 2'd2);
    o_in_ready  = i_rstn && !o_full && !(rd_req && (token == TOK_RD));
    wr_fire     = i_in_valid && o_in_ready;
    rd_grant    = rd_req && !wr_fire;
    push        = inflight;
    o_out_valid = (obuf_cnt != 2'd0);
    pop         = o_out_valid && i_out_ready;
    wsel        = obuf_cnt - 2'(pop);
    o_out_data  = obuf0;
    o_count     = CW'(mem_cnt) + CW'(inflight) + CW'(obuf_cnt);
    o_empty     = (o_count == '0);
    o_sram_cen  = wr_fire || rd_grant;
    o_sram_wen  = wr_fire;
    o_sram_addr = wr_fire ? wr_ptr[BW_ADDR-1:0] : rd_ptr[BW_ADDR-1:0];
    o_sram_data = i_in_data;
    o_sram_oen  = rd_grant || inflight;
  end

  // Pointers, read-return tracking and port token
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      token    <= TOK_RD;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_grant) rd_ptr <= rd_ptr + PW'(1);
      inflight <= rd_grant;
      if (rd_grant) begin
        token <= TOK_WR;
      end else if (wr_fire && rd_req) begin
        token <= TOK_RD;
      end
    end
  end

  // Output buffer: head in obuf0, returning word lands behind any survivor
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      obuf0    <= '0;
      obuf1    <= '0;
      obuf_cnt <= 2'd0;
    end else begin
      if (pop) obuf0 <= obuf1;
      if (push) begin
        if (wsel == 2'd0) obuf0 <= i_sram_data;
        else              obuf1 <= i_sram_data;
      end
      obuf_cnt <= obuf_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
// Directed bench for spsram_fifo_ctrl with a behavioural single-port SRAM.
module tb_spsram_fifo_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  count;
  logic        full;
  logic        empty;
  logic [31:0] sram_wdata;
  logic [4:0]  sram_addr;
  logic        cen;
  logic        wen;
  logic        oen;
  logic [31:0] sram_rdata;

  logic [31:0] sram_mem [32];

  int n_checks;
  int n_fail;

  spsram_fifo_ctrl #(.BW_DATA(32), .BW_ADDR(5)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_count     (count),
    .o_full      (full),
    .o_empty     (empty),
    .o_sram_data (sram_wdata),
    .o_sram_addr (sram_addr),
    .o_sram_cen  (cen),
    .o_sram_wen  (wen),
    .o_sram_oen  (oen),
    .i_sram_data (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: write at the edge, read data valid the cycle after
  always @(posedge clk) begin
    if (cen && wen) sram_mem[sram_addr] <= sram_wdata;
    if (cen && !wen && oen) sram_rdata <= sram_mem[sram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int got;
    int sent;
    int recv;
    int cyc;
    bit found;

    n_checks   = 0;
    n_fail     = 0;
    sram_rdata = 32'h0;
    rstn       = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_ready  = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_cen", 64'(cen), 64'd0);
    check("rst_wen", 64'(wen), 64'd0);
    check("rst_oen", 64'(oen), 64'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Single word latency
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    #1;
    check("lat_c0_ready", 64'(in_ready), 64'd1);
    check("lat_c0_write", 64'({cen, wen}), 64'b11);
    step();
    in_valid = 1'b0;
    #1;
    check("lat_c1_valid", 64'(out_valid), 64'd0);
    check("lat_c1_read", 64'({cen, wen, oen}), 64'b101);
    step();
    #1;
    check("lat_c2_valid", 64'(out_valid), 64'd0);
    check("lat_c2_oen", 64'({cen, oen}), 64'b01);
    step();
    #1;
    check("lat_c3_valid", 64'(out_valid), 64'd1);
    check("lat_c3_data", 64'(out_data), 64'hDEADBEEF);
    step();
    #1;
    check("lat_c4_valid", 64'(out_valid), 64'd0);
    check("lat_c4_empty", 64'(empty), 64'd1);
    step();

    // Fill with output stalled: DEPTH + 2 words fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 120; c++) begin
      in_data = 32'h100 + 32'(acc);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    #1;
    check("fill_accepted", 64'(acc), 64'd34);
    check("fill_count", 64'(count), 64'd34);
    check("fill_full", 64'(full), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_head", 64'(out_data), 64'h100);
    step();

    // Drain in order
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 34; c++) begin
      #1;
      if (out_valid) begin
        check("drain_data", 64'(out_data), 64'(32'h100 + 32'(got)));
        got++;
      end
      step();
    end
    #1;
    check("drain_words", 64'(got), 64'd34);
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_full", 64'(full), 64'd0);
    step();

    // Concurrent stream of 100 words
    sent = 0;
    recv = 0;
    cyc  = 0;
    out_ready = 1'b1;
    while (recv < 100 && cyc < 400) begin
      in_valid = (sent < 100);
      in_data  = 32'(sent);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        check("stream_data", 64'(out_data), 64'(recv));
        recv++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("stream_sent", 64'(sent), 64'd100);
    check("stream_recv", 64'(recv), 64'd100);
    check("stream_rate", 64'(cyc <= 215), 64'd1);
    check("stream_empty", 64'(empty), 64'd1);
    step();

    // Random stalls across pointer wrap, count tracked by scoreboard
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 80 && cyc < 3000) begin
      in_valid  = (sent < 80) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      in_data   = 32'h1000 + 32'(sent);
      #1;
      check("wrap_count", 64'(count), 64'(sent - recv));
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("wrap_data", 64'(out_data), 64'(32'h1000 + 32'(recv)));
        recv++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("wrap_recv", 64'(recv), 64'd80);
    check("wrap_empty", 64'(empty), 64'd1);
    step();

    // Reset with a read in flight and one word buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      in_data = 32'hA0 + 32'(c);
      #1;
      if (out_valid && oen && !(cen && !wen)) found = 1'b1;
      else step();
    end
    check("midrst_found", 64'(found), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_cen", 64'(cen), 64'd0);
    in_valid = 1'b0;
    #2 rstn = 1'b1;
    step();
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (out_valid) found = 1'b1;
      else step();
    end
    check("post_rst_seen", 64'(found), 64'd1);
    check("post_rst_data", 64'(out_data), 64'h55);
    step();
    #1;
    check("post_rst_empty", 64'(empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spsram_fifo_ctrl.md
Name: spsram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the spsram single-port macro (same BW_DATA/BW_ADDR) as its storage array.
- Accepts a valid/ready input stream and issues SRAM write and read commands, arbitrating the single port between them.
- Returns read data through a 2-entry output buffer onto a valid/ready output stream.
- Sits directly upstream of spsram; spsram's o_data feeds back into this block.

Parameters:
BW_DATA, 32, data word width (matches spsram BW_DATA)
BW_ADDR, 5, SRAM address width; SRAM depth DEPTH = 2**BW_ADDR

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_in_data  input  BW_DATA  write-stream data
i_in_valid  input  1  write-stream valid
o_in_ready  output  1  write-stream ready
o_out_data  output  BW_DATA  read-stream data (output buffer head)
i_out_ready  input  1  read-stream ready
o_out_valid  output  1  read-stream valid
o_count  output  BW_ADDR+2  total entries held (SRAM + in-flight + output buffer), max DEPTH+2
o_full  output  1  SRAM storage full
o_empty  output  1  o_count==0
o_sram_data  output  BW_DATA  to spsram i_data
o_sram_addr  output  BW_ADDR  to spsram i_addr
o_sram_cen  output  1  to spsram i_cen (active high)
o_sram_wen  output  1  to spsram i_wen (1=write)
o_sram_oen  output  1  to spsram i_oen (active high)
i_sram_data  input  BW_DATA  from spsram o_data

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rstn is asynchronous, active-low.
- SRAM contract:
  - Write commits at the edge where cen=1, wen=1.
  - Read command (cen=1, wen=0, oen=1) at edge E returns data on i_sram_data during the cycle after E; oen is held in that cycle.
- State: wr_ptr, rd_ptr (BW_ADDR+1 bits each, wrap naturally); inflight (1 bit); obuf (2 entries) with obuf_cnt (0..2); token (RD/WR).
- mem_cnt = wr_ptr - rd_ptr. o_full = (mem_cnt == DEPTH).
- rd_req = (mem_cnt != 0) && (obuf_cnt + inflight < 2). The pop in the same cycle is not considered.
- Arbitration and handshake:
  - o_in_ready = !o_full && !(rd_req && token==RD). o_in_ready never depends on i_in_valid.
  - wr_fire = i_in_valid && o_in_ready.
  - rd_grant = rd_req && !wr_fire.
- SRAM drive (combinational):
  - o_sram_cen = wr_fire | rd_grant; o_sram_wen = wr_fire.
  - o_sram_addr = wr_fire ? wr_ptr[BW_ADDR-1:0] : rd_ptr[BW_ADDR-1:0].
  - o_sram_data = i_in_data; o_sram_oen = rd_grant | inflight.
- Sequential updates:
  - wr_fire: wr_ptr+1.
  - rd_grant: rd_ptr+1; inflight<=1, else inflight<=0.
  - inflight=1: i_sram_data pushed into obuf.
  - o_out_valid && i_out_ready: obuf pops.
  - Push and pop in the same cycle are both honoured.
- Token: after a read grant, token<=WR. After a wr_fire with rd_req=1, token<=RD. Otherwise unchanged.
- Latency:
  - Word accepted in cycle 0 into an empty FIFO: read in cycle 1, return in cycle 2, o_out_valid in cycle 3.
  - Steady concurrent in/out traffic alternates the port; throughput is 1 word per 2 cycles each way.
- Ordering and capacity:
  - Strict FIFO order.
  - Capacity DEPTH+2 (obuf entries no longer occupy SRAM).
  - o_count = mem_cnt + inflight + obuf_cnt.
- Boundary conditions:
  - Full: o_in_ready=0; i_in_data is ignored.
  - Empty: no SRAM read; o_out_valid=0.
  - Pointer wrap past DEPTH is transparent.
  - A stalled output (i_out_ready=0) stops reads once obuf_cnt + inflight = 2. The in-flight word is always accepted into obuf.
- Reset values and mid-operation reset:
  - While i_rstn=0: pointers, inflight, obuf_cnt = 0; token = RD.
  - Outputs during reset: o_out_valid=0, o_out_data=0, o_count=0, o_empty=1, o_full=0, o_sram_cen=0, o_sram_wen=0, o_sram_oen=0.
  - o_in_ready=1 once reset releases.
  - Reset mid-operation discards all contents, including any in-flight read. SRAM array contents are left untouched but are logically invalid.

Test Plan:
- Reset: assert i_rstn=0 mid-cycle -> o_out_valid=0, o_empty=1, o_count=0, o_sram_cen=0 immediately; o_in_ready=1 after release.
- Single word latency: push 0xDEADBEEF in cycle 0 with i_out_ready=1 -> o_out_valid=1 with 0xDEADBEEF first in cycle 3; o_empty=1 after pop.
- Fill: i_out_ready=0, push 0x100+i continuously -> exactly 34 words accepted (0x100..0x121); o_count=34, o_full=1, o_in_ready=0. Then drain -> 0x100..0x121 in order, o_empty=1.
- Concurrent stream: both valid and ready held 1, 100 words i -> output 0..99 in order, no loss; o_in_ready and SRAM writes alternate with reads after warm-up.
- Wrap: 80 words with random i_in_valid/i_out_ready stalls -> pointers wrap twice; scoreboard matches; o_count never exceeds 34.
- Reset mid-stream: reset in a cycle where inflight=1 and obuf_cnt=1 -> count 0 immediately. Post-reset push 0x55 -> first output is 0x55.
